// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and requester ids for the dmem arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;
  localparam logic OWNER_P0 = 1'b0;
  localparam logic OWNER_P1 = 1'b1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and dmem-side signals of the arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 12, parameter int DATA_W = 32);
  logic              p0_req, p0_wren, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_wren, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic              mem_wren;
  modport slave (
    input  p0_req, p0_wren, p0_addr, p0_wdata, p1_req, p1_wren, p1_addr, p1_wdata, mem_q,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, mem_address, mem_data, mem_wren
  );
  modport master (
    output p0_req, p0_wren, p0_addr, p0_wdata, p1_req, p1_wren, p1_addr, p1_wdata, mem_q,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/dmem_arb_rdpipe.sv
// dmem_arb_rdpipe: LAT-deep {valid, owner} shift register tracking in-flight reads
module dmem_arb_rdpipe #(parameter int LAT = 1) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);
  logic [LAT-1:0] v_q, o_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      o_q <= '0;
    end else begin
      v_q[0] <= push_i;
      o_q[0] <= owner_i;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        o_q[i] <= o_q[i-1];
      end
    end
  end
  assign valid_o = v_q[LAT-1];
  assign owner_o = o_q[LAT-1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: burst-aware round-robin sharing of one dmem port between two requesters.
// Define DMEM_ARB_STATS_EN to add beat/conflict statistics counters.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input logic clock,
  input logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_beats0,
  output logic [31:0] stat_beats1,
  output logic [31:0] stat_conflicts
`endif
);
  typedef struct packed {logic wren; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} beat_t;
  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [7:0]        cnt_q, cnt_d, c;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              any, sel, cont, other, sw, go, pv, po;
  beat_t             b0, b1, b;
  assign b0 = '{bus.p0_wren, bus.p0_addr, bus.p0_wdata};
  assign b1 = '{bus.p1_wren, bus.p1_addr, bus.p1_wdata};
  // sel is the port that would win this cycle; c is the owner's beat count before this beat
  always_comb begin
    any       = bus.p0_req | bus.p1_req;
    sel       = state_q == OWN0 ? !bus.p0_req :
                state_q == OWN1 ? bus.p1_req :
                (bus.p0_req && bus.p1_req) ? !rr_last_q : bus.p1_req;
    cont      = (state_q == OWN0 && !sel) || (state_q == OWN1 && sel);
    c         = cont ? cnt_q : 8'd0;
    other     = sel ? bus.p0_req : bus.p1_req;
    sw        = other && c == 8'(MAX_BURST - 1);
    state_d   = !any ? IDLE : ((sel ^ sw) ? OWN1 : OWN0);
    cnt_d     = (!any || sw) ? 8'd0 : (c == 8'(MAX_BURST - 1) ? c : c + 8'd1);
    rr_last_d = any ? sel : rr_last_q;
    go        = reset && any;
    b         = sel ? b1 : b0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      if (go) begin
        addr_q <= b.addr;
        data_q <= b.wdata;
      end
    end
  end
  assign bus.p0_gnt      = go && !sel;
  assign bus.p1_gnt      = go && sel;
  assign bus.mem_wren    = go && b.wren;
  assign bus.mem_address = go ? b.addr : addr_q;
  assign bus.mem_data    = go ? b.wdata : data_q;
  dmem_arb_rdpipe #(.LAT(READ_LAT)) u_rdpipe (
    .clk(clock), .rst_n(reset), .push_i(go && !b.wren), .owner_i(sel), .valid_o(pv), .owner_o(po)
  );
  assign bus.p0_rvalid = pv && po == OWNER_P0;
  assign bus.p1_rvalid = pv && po == OWNER_P1;
  assign bus.p0_rdata  = bus.mem_q;
  assign bus.p1_rdata  = bus.mem_q;
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_beats0    <= '0;
      stat_beats1    <= '0;
      stat_conflicts <= '0;
    end else begin
      if (go && !sel) stat_beats0 <= stat_beats0 + 32'd1;
      if (go && sel) stat_beats1 <= stat_beats1 + 32'd1;
      if (bus.p0_req && bus.p1_req) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif
endmodule
